// File: rtl/stopwatch_core.sv
// BCD MM:SS stopwatch / countdown core with a speed-scaled step divider.
// Defining STOPWATCH_LAP_EN enables lap capture; otherwise the lap outputs are tied to 0.
module stopwatch_core #(
  parameter int BASE_DIV = 12500000,
  parameter int SPD_MAX  = 2,
  parameter int MIN_MAX  = 59,
  localparam int SPD_W   = (SPD_MAX > 0) ? $clog2(SPD_MAX + 1) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_tgl,
  input  logic             dir_tgl,
  input  logic             fast,
  input  logic             slow,
  input  logic             clr,
  input  logic             load,
  input  logic [7:0]       load_mm,
  input  logic [7:0]       load_ss,
  input  logic             lap,
  output logic [7:0]       mm,
  output logic [7:0]       ss,
  output logic             running,
  output logic             down,
  output logic [SPD_W-1:0] speed,
  output logic             step,
  output logic             done,
  output logic [7:0]       lap_mm,
  output logic [7:0]       lap_ss,
  output logic [3:0]       lap_cnt
);

  localparam int DIV_W = $clog2(BASE_DIV << SPD_MAX);
  localparam logic [SPD_W-1:0] SPD_TOP = SPD_W'(SPD_MAX);
  localparam logic [7:0] MIN_BCD = {4'(MIN_MAX / 10), 4'(MIN_MAX % 10)};

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    return (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : v - 8'd1;
  endfunction

  logic [DIV_W-1:0] div_q, div_d, div_tc;
  logic [7:0]       mm_d, ss_d;
  logic             run_d, down_d, step_d, done_d, tick;
  logic [SPD_W-1:0] speed_d;
  logic             load_ok, spd_up, spd_dn;

  assign div_tc  = DIV_W'((BASE_DIV << speed) - 1);
  assign load_ok = (load_mm[7:4] <= 4'd9) && (load_mm[3:0] <= 4'd9) &&
                   (load_ss[7:4] <= 4'd5) && (load_ss[3:0] <= 4'd9) &&
                   (load_mm <= MIN_BCD);
  assign spd_up  = slow && !fast && (speed != SPD_TOP);
  assign spd_dn  = fast && !slow && (speed != '0);

  always_comb begin
    mm_d    = mm;
    ss_d    = ss;
    run_d   = running;
    down_d  = down;
    speed_d = speed;
    div_d   = div_q;
    step_d  = 1'b0;
    done_d  = 1'b0;
    tick    = running && (div_q == div_tc);
    if (clr) begin
      mm_d  = '0;
      ss_d  = '0;
      run_d = 1'b0;
      div_d = '0;
    end else begin
      if (load && load_ok) begin
        mm_d  = load_mm;
        ss_d  = load_ss;
        run_d = 1'b0;
        div_d = '0;
      end else begin
        if (running) div_d = tick ? '0 : div_q + 1'b1;
        if (tick) begin
          step_d = 1'b1;
          if (!down) begin
            if (ss == 8'h59) begin
              ss_d = '0;
              mm_d = (mm == MIN_BCD) ? 8'h00 : bcd_inc(mm);
            end else begin
              ss_d = bcd_inc(ss);
            end
          end else begin
            // a step already at 00:00 holds the time but still terminates
            if (ss != 8'h00) ss_d = bcd_dec(ss);
            else if (mm != 8'h00) begin
              ss_d = 8'h59;
              mm_d = bcd_dec(mm);
            end
            if (mm_d == 8'h00 && ss_d == 8'h00) begin
              done_d = 1'b1;
              run_d  = 1'b0;
            end
          end
        end
        if (run_tgl) run_d = (down && mm_d == 8'h00 && ss_d == 8'h00) ? 1'b0 : !run_d;
      end
      if (dir_tgl) down_d = !down;
      if (spd_up) begin
        speed_d = speed + 1'b1;
        div_d   = '0;
      end else if (spd_dn) begin
        speed_d = speed - 1'b1;
        div_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mm      <= '0;
      ss      <= '0;
      running <= 1'b0;
      down    <= 1'b0;
      speed   <= '0;
      div_q   <= '0;
      step    <= 1'b0;
      done    <= 1'b0;
    end else begin
      mm      <= mm_d;
      ss      <= ss_d;
      running <= run_d;
      down    <= down_d;
      speed   <= speed_d;
      div_q   <= div_d;
      step    <= step_d;
      done    <= done_d;
    end
  end

`ifdef STOPWATCH_LAP_EN
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      lap_mm  <= '0;
      lap_ss  <= '0;
      lap_cnt <= '0;
    end else if (lap) begin
      lap_mm <= mm;
      lap_ss <= ss;
      if (lap_cnt != 4'd15) lap_cnt <= lap_cnt + 4'd1;
    end
  end
`else
  logic lap_unused;
  assign lap_unused = lap;
  assign lap_mm     = '0;
  assign lap_ss     = '0;
  assign lap_cnt    = '0;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core (BASE_DIV=4, SPD_MAX=2, MIN_MAX=59): vector table,
// directed multi-cycle sequences and a randomized run against a seconds-based model.
module tb_stopwatch_core;

`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  localparam logic [6:0] RT = 7'b1000000;
  localparam logic [6:0] DT = 7'b0100000;
  localparam logic [6:0] FA = 7'b0010000;
  localparam logic [6:0] SL = 7'b0001000;
  localparam logic [6:0] CL = 7'b0000100;
  localparam logic [6:0] LD = 7'b0000010;
  localparam logic [6:0] LP = 7'b0000001;
  localparam logic [6:0] NO = 7'b0000000;

  logic       clk = 1'b0;
  logic       rst, run_tgl, dir_tgl, fast, slow, clr, load, lap;
  logic [7:0] load_mm, load_ss;
  logic [7:0] mm, ss, lap_mm, lap_ss;
  logic       running, down, step, done;
  logic [1:0] speed;
  logic [3:0] lap_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  stopwatch_core #(.BASE_DIV(4), .SPD_MAX(2), .MIN_MAX(59)) dut (
    .clk(clk), .rst(rst), .run_tgl(run_tgl), .dir_tgl(dir_tgl), .fast(fast),
    .slow(slow), .clr(clr), .load(load), .load_mm(load_mm), .load_ss(load_ss),
    .lap(lap), .mm(mm), .ss(ss), .running(running), .down(down), .speed(speed),
    .step(step), .done(done), .lap_mm(lap_mm), .lap_ss(lap_ss), .lap_cnt(lap_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] ctl;
    logic [7:0] lmm, lss;
    logic [7:0] emm, ess;
    logic [1:0] ers;   // {running, down}
    logic [1:0] espd;
  } vec_t;

  vec_t vecs[18];

  // reference model: time kept as total seconds
  int m_t, m_run, m_down, m_spd, m_ph, m_lt, m_lc, m_step, m_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] c, input logic [7:0] lmm, input logic [7:0] lss);
    {run_tgl, dir_tgl, fast, slow, clr, load, lap} = c;
    load_mm = lmm;
    load_ss = lss;
  endtask

  task automatic pulse(input logic [6:0] c, input logic [7:0] lmm, input logic [7:0] lss);
    drive(c, lmm, lss);
    tick();
    drive(NO, 8'h00, 8'h00);
  endtask

  task automatic do_reset();
    drive(NO, 8'h00, 8'h00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_step(input int budget, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!step && cyc < budget);
    check("step_seen", 64'(step), 64'd1);
  endtask

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic int bcd_val(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [63:0] exp_pack();
    return {22'd0, bcd(m_t / 60), bcd(m_t % 60), 1'(m_run), 1'(m_down), 2'(m_spd),
            1'(m_step), 1'(m_done), bcd(m_lt / 60), bcd(m_lt % 60), 4'(m_lc)};
  endfunction

  function automatic logic [63:0] act_pack();
    return {22'd0, mm, ss, running, down, speed, step, done, lap_mm, lap_ss, lap_cnt};
  endfunction

  task automatic model_edge();
    int pre_t, period;
    bit hit;
    if (rst) begin
      m_t = 0; m_run = 0; m_down = 0; m_spd = 0; m_ph = 0;
      m_lt = 0; m_lc = 0; m_step = 0; m_done = 0;
      return;
    end
    m_step = 0;
    m_done = 0;
    pre_t  = m_t;
    period = 4 << m_spd;
    hit    = 1'b0;
    if (clr) begin
      m_t = 0; m_run = 0; m_ph = 0; m_lt = 0; m_lc = 0;
    end else begin
      if (load && load_mm[7:4] <= 9 && load_mm[3:0] <= 9 && load_ss[7:4] <= 5 &&
          load_ss[3:0] <= 9 && bcd_val(load_mm) <= 59) begin
        m_t = bcd_val(load_mm) * 60 + bcd_val(load_ss);
        m_run = 0;
        m_ph = 0;
      end else begin
        if (m_run != 0) begin
          if (m_ph == period - 1) begin m_ph = 0; hit = 1'b1; end
          else m_ph++;
        end
        if (hit) begin
          m_step = 1;
          if (m_down == 0) m_t = (m_t + 1) % 3600;
          else begin
            if (m_t > 0) m_t--;
            if (m_t == 0) begin m_done = 1; m_run = 0; end
          end
        end
        if (run_tgl) m_run = (m_down != 0 && m_t == 0) ? 0 : int'(m_run == 0);
      end
      if (dir_tgl) m_down = int'(m_down == 0);
      if (slow && !fast && m_spd < 2) begin m_spd++; m_ph = 0; end
      else if (fast && !slow && m_spd > 0) begin m_spd--; m_ph = 0; end
      if (LAP_EN && lap) begin
        m_lt = pre_t;
        if (m_lc < 15) m_lc++;
      end
    end
  endtask

  initial begin
    int c;
    rst = 1'b0;
    drive(NO, 8'h00, 8'h00);

    vecs[0]  = '{NO,      8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'd0};
    vecs[1]  = '{SL,      8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'd1};
    vecs[2]  = '{SL,      8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'd2};
    vecs[3]  = '{SL,      8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'd2};
    vecs[4]  = '{FA | SL, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'd2};
    vecs[5]  = '{FA,      8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'd1};
    vecs[6]  = '{FA,      8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'd0};
    vecs[7]  = '{FA,      8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'd0};
    vecs[8]  = '{LD,      8'h1A, 8'h00, 8'h00, 8'h00, 2'b00, 2'd0};
    vecs[9]  = '{LD,      8'h99, 8'h00, 8'h00, 8'h00, 2'b00, 2'd0};
    vecs[10] = '{LD,      8'h00, 8'h60, 8'h00, 8'h00, 2'b00, 2'd0};
    vecs[11] = '{LD,      8'h59, 8'h59, 8'h59, 8'h59, 2'b00, 2'd0};
    vecs[12] = '{LD,      8'h12, 8'h34, 8'h12, 8'h34, 2'b00, 2'd0};
    vecs[13] = '{LD,      8'h60, 8'h00, 8'h12, 8'h34, 2'b00, 2'd0};
    vecs[14] = '{RT|CL|LD,8'h05, 8'h05, 8'h00, 8'h00, 2'b00, 2'd0};
    vecs[15] = '{DT,      8'h00, 8'h00, 8'h00, 8'h00, 2'b01, 2'd0};
    vecs[16] = '{RT,      8'h00, 8'h00, 8'h00, 8'h00, 2'b01, 2'd0};
    vecs[17] = '{DT,      8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'd0};

    do_reset();
    check("rst_mm", 64'(mm), 64'h00);
    check("rst_ss", 64'(ss), 64'h00);
    check("rst_running", 64'(running), 64'd0);
    check("rst_down", 64'(down), 64'd0);
    check("rst_speed", 64'(speed), 64'd0);
    check("rst_step", 64'(step), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_lap", 64'({lap_mm, lap_ss, lap_cnt}), 64'd0);

    for (int i = 0; i < 18; i++) begin
      pulse(vecs[i].ctl, vecs[i].lmm, vecs[i].lss);
      check($sformatf("vec%0d_time", i), 64'({mm, ss}), 64'({vecs[i].emm, vecs[i].ess}));
      check($sformatf("vec%0d_run_down", i), 64'({running, down}), 64'(vecs[i].ers));
      check($sformatf("vec%0d_speed", i), 64'(speed), 64'(vecs[i].espd));
      check($sformatf("vec%0d_step", i), 64'(step), 64'd0);
    end

    // count up: digit carry, minute carry, full wrap
    pulse(LD, 8'h00, 8'h08);
    pulse(RT, 8'h00, 8'h00);
    wait_step(40, c);
    check("up_first_period", 64'(c), 64'd4);
    check("up_09", 64'({mm, ss}), 64'h0009);
    wait_step(40, c);
    check("up_period", 64'(c), 64'd4);
    check("up_10", 64'({mm, ss}), 64'h0010);
    pulse(LD, 8'h00, 8'h59);
    pulse(RT, 8'h00, 8'h00);
    wait_step(40, c);
    check("up_min_carry", 64'({mm, ss}), 64'h0100);
    pulse(LD, 8'h59, 8'h59);
    pulse(RT, 8'h00, 8'h00);
    wait_step(40, c);
    check("up_wrap", 64'({mm, ss}), 64'h0000);
    check("up_wrap_running", 64'(running), 64'd1);
    check("up_wrap_done", 64'(done), 64'd0);

    // speed saturation and period
    pulse(CL, 8'h00, 8'h00);
    repeat (3) pulse(SL, 8'h00, 8'h00);
    check("slow_sat", 64'(speed), 64'd2);
    pulse(RT, 8'h00, 8'h00);
    wait_step(100, c);
    check("slow_first_period", 64'(c), 64'd16);
    wait_step(100, c);
    check("slow_period", 64'(c), 64'd16);
    repeat (3) pulse(FA, 8'h00, 8'h00);
    check("fast_sat", 64'(speed), 64'd0);
    pulse(FA | SL, 8'h00, 8'h00);
    check("fast_slow_same", 64'(speed), 64'd0);
    pulse(CL, 8'h00, 8'h00);

    // countdown to done
    pulse(LD, 8'h00, 8'h02);
    pulse(DT, 8'h00, 8'h00);
    pulse(RT, 8'h00, 8'h00);
    wait_step(40, c);
    check("dn_period", 64'(c), 64'd4);
    check("dn_01", 64'({mm, ss}), 64'h0001);
    check("dn_01_done", 64'(done), 64'd0);
    check("dn_01_running", 64'(running), 64'd1);
    wait_step(40, c);
    check("dn_00", 64'({mm, ss}), 64'h0000);
    check("dn_00_done", 64'(done), 64'd1);
    check("dn_00_running", 64'(running), 64'd0);
    tick();
    check("dn_done_pulse_width", 64'({step, done}), 64'd0);
    pulse(RT, 8'h00, 8'h00);
    check("dn_run_at_zero", 64'(running), 64'd0);

    // reset mid-count
    do_reset();
    pulse(SL, 8'h00, 8'h00);
    pulse(DT, 8'h00, 8'h00);
    pulse(LD, 8'h12, 8'h34);
    pulse(RT, 8'h00, 8'h00);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstrun_all", 64'({mm, ss, running, down, speed, step, done}), 64'd0);
    pulse(RT, 8'h00, 8'h00);
    wait_step(40, c);
    check("rstrun_div_restart", 64'(c), 64'd4);
    check("rstrun_count", 64'({mm, ss}), 64'h0001);

    // lap capture
    do_reset();
    pulse(LD, 8'h00, 8'h05);
    pulse(LP, 8'h00, 8'h00);
    check("lap_ss", 64'(lap_ss), LAP_EN ? 64'h05 : 64'h00);
    check("lap_mm", 64'(lap_mm), 64'h00);
    check("lap_cnt1", 64'(lap_cnt), LAP_EN ? 64'd1 : 64'd0);
    repeat (15) pulse(LP, 8'h00, 8'h00);
    check("lap_cnt_sat", 64'(lap_cnt), LAP_EN ? 64'd15 : 64'd0);
    pulse(LP | CL, 8'h00, 8'h00);
    check("lap_clr_wins", 64'({lap_mm, lap_ss, lap_cnt}), 64'd0);

    // randomized run against the model
    do_reset();
    model_edge();
    for (int i = 0; i < 4000; i++) begin
      drive(NO, 8'h00, 8'h00);
      rst     = ($urandom_range(0, 149) == 0);
      run_tgl = ($urandom_range(0, 11) == 0);
      dir_tgl = ($urandom_range(0, 24) == 0);
      fast    = ($urandom_range(0, 29) == 0);
      slow    = ($urandom_range(0, 29) == 0);
      lap     = ($urandom_range(0, 19) == 0);
      clr     = ($urandom_range(0, 119) == 0);
      load    = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 3))
        0: begin load_mm = 8'h00; load_ss = bcd(int'($urandom_range(0, 3))); end
        1: begin load_mm = 8'($urandom); load_ss = 8'($urandom); end
        2: begin load_mm = bcd(int'($urandom_range(0, 59))); load_ss = bcd(int'($urandom_range(0, 59))); end
        default: begin load_mm = 8'h59; load_ss = bcd(int'($urandom_range(55, 59))); end
      endcase
      if (clr || load) begin dir_tgl = 1'b0; fast = 1'b0; slow = 1'b0; lap = 1'b0; end
      if (run_tgl) dir_tgl = 1'b0;
      if (m_run != 0 && m_ph == (4 << m_spd) - 1) begin fast = 1'b0; slow = 1'b0; end
      model_edge();
      tick();
      check($sformatf("rand%0d", i), act_pack(), exp_pack());
    end
    drive(NO, 8'h00, 8'h00);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Parametrised MM:SS stopwatch/countdown timer core. It counts in BCD at a selectable speed. Speed control saturates at its limits, and the block supports clear, preset load and countdown completion with a done pulse. It sits between the debounced, one-cycle-pulse button logic and the 7-segment decoders, which consume `mm`, `ss` and `speed`.

## Interface
- `BASE_DIV`, default 12500000: clock cycles per count step at speed 0; must be ≥ 2.
- `SPD_MAX`, default 2: highest speed code. Step period = `BASE_DIV << speed`.
- `MIN_MAX`, default 59: highest minute value, in binary; range 1..99.
- Derived, local: `SPD_W = $clog2(SPD_MAX+1)` (minimum 1); divider width = `$clog2(BASE_DIV << SPD_MAX)`.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `run_tgl` in 1: pulse; toggles running.
- `dir_tgl` in 1: pulse; toggles count direction.
- `fast` in 1: pulse; speed code −1.
- `slow` in 1: pulse; speed code +1.
- `clr` in 1: pulse; zero time and stop.
- `load` in 1: pulse; preset time from `load_mm`/`load_ss`.
- `load_mm` in 8: BCD minutes preset.
- `load_ss` in 8: BCD seconds preset.
- `lap` in 1: pulse; capture lap (used only with `LAP_EN`).
- `mm` out 8: BCD minutes.
- `ss` out 8: BCD seconds.
- `running` out 1: counting enabled.
- `down` out 1: 1 = countdown.
- `speed` out `SPD_W`: current speed code; 0 is fastest.
- `step` out 1: one-cycle pulse, coincident with each time update.
- `done` out 1: one-cycle pulse when a countdown terminates.
- `lap_mm`, `lap_ss` out 8 each: captured lap time.
- `lap_cnt` out 4: laps captured, saturating.

## Operation
- Reset values: `mm = ss = 0`, `running = 0`, `down = 0`, `speed = 0`, divider = 0, `step = done = 0`, `lap_mm = lap_ss = lap_cnt = 0`.
- Priority per edge: `rst` > `clr` > `load` > all other inputs. When `clr` or `load` is taken, `run_tgl` and the step are suppressed that cycle.
- `clr`: time = 00:00, `running = 0`, divider = 0, lap registers = 0. `down` and `speed` are kept.
- `load`: accepted only if every nibble is ≤ 9, the `ss` tens nibble is ≤ 5, and `load_mm` ≤ `MIN_MAX`. If accepted: time = preset, `running = 0`, divider = 0. If invalid, nothing changes.
- `run_tgl`: toggles `running`. Exception: in countdown mode at 00:00, `running` is forced to 0.
- `dir_tgl`: toggles `down`; the divider is not disturbed.
- `fast`/`slow`: decrement/increment `speed`, saturating at 0 and `SPD_MAX`. If both arrive in the same cycle, there is no change. Any actual speed change zeroes the divider.
- Divider: increments only while `running`. When it reaches `(BASE_DIV << speed) − 1`, it wraps to 0 on that edge, time updates and `step = 1`.
- Count-up: `ss` +1; 59 → 00 with `mm` +1. At `MIN_MAX`:59 it wraps to 00:00 and keeps running.
- Countdown: `ss` −1; 00 → 59 with `mm` −1.
  - A step that lands on 00:00 asserts `done` and clears `running` on the same edge.
  - A step taken while already at 00:00 (direction flipped while running) holds 00:00, pulses `done` and clears `running`.
- A step and `run_tgl` in the same cycle: the step is evaluated against the pre-edge `running`; the toggle applies afterward.
- A step and `dir_tgl` in the same cycle: the step uses the pre-edge direction.

## Timing
- All outputs are registered and change only on `clk` rising edges. The block has no combinational input-to-output paths.
- If `running` rises at edge E with divider = 0, the first update is at edge E + `BASE_DIV << speed`, with the same period thereafter.
- `step` and `done` are high for exactly one cycle, aligned with the updated `mm`/`ss`.
- Pause/resume preserves the divider phase. `clr`, `load` and any speed change restart it.
- `rst` mid-count takes effect on the next edge; no pulse outputs are produced in that cycle.

## Configuration
- `STOPWATCH_LAP_EN` defined:
  - `lap` captures the pre-edge `mm`/`ss` into `lap_mm`/`lap_ss` and increments `lap_cnt`, saturating at 15.
  - A capture is allowed whether or not the block is running.
  - If `clr` arrives in the same cycle, `clr` wins.
- `STOPWATCH_LAP_EN` undefined: the lap ports remain; `lap` is ignored and `lap_mm`, `lap_ss`, `lap_cnt` are constant 0.

## Test plan
All scenarios use `BASE_DIV = 4`, `SPD_MAX = 2`, `MIN_MAX = 59`.
- Reset, `run_tgl`, count up: `step` every 4 cycles; `ss` goes 00 → 09 → 10 and 59 → `mm` 01, `ss` 00; `MIN_MAX`:59 wraps to 00:00 with `running` still 1.
- `slow` ×3: `speed` = 2 (saturated) and the step period is 16 cycles. `fast` ×3: `speed` = 0. `fast` and `slow` in one cycle: `speed` unchanged.
- Load 00:02, `dir_tgl`, `run_tgl`: 00:01, then 00:00 with `done` = 1 for 1 cycle and `running` = 0. A further `run_tgl` leaves `running` at 0.
- Invalid loads `load_ss = 8'h60`, `load_mm = 8'h1A`, `load_mm = 8'h99`: time unchanged. Valid 59:59 is accepted.
- `clr` with `run_tgl` and `load` in the same cycle: 00:00, `running` = 0. `rst` while running at 12:34: all outputs return to their reset values on the next edge.
- With `STOPWATCH_LAP_EN`: `lap` at 00:05 gives `lap_ss = 8'h05`, `lap_cnt = 1`; 16 laps hold `lap_cnt = 15`. Without the macro, the lap outputs stay 0.
